// File: rtl/pergate_seq_pkg.sv
// rtl/pergate_seq_pkg.sv - shared types and field constants for the per-gate sequencer
package pergate_seq_pkg;

  // Field is the Mersenne prime 2^61 - 1; values are carried in F_NBITS bits.
  localparam int F_NBITS = 61;
  localparam logic [F_NBITS-1:0] F_Q   = {F_NBITS{1'b1}};
  localparam logic [F_NBITS-1:0] F_ONE = F_NBITS'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RESTART  = 3'd1,
    S_WAIT_TAU = 3'd2,
    S_WAIT_RDY = 3'd3,
    S_FIRE     = 3'd4,
    S_DONE     = 3'd5
  } seq_state_t;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int round_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/field_one_minus.sv
// rtl/field_one_minus.sv - combinational (1 - x) mod F_Q for reduced field elements
module field_one_minus
  import pergate_seq_pkg::*;
(
  input  logic [F_NBITS-1:0] i_x,
  output logic [F_NBITS-1:0] o_y
);

  // x is already reduced, so 0 and 1 are the only inputs whose result is not q + 1 - x.
  always_comb begin
    o_y = '0;
    if (i_x == '0) begin
      o_y = F_ONE;
    end else if (i_x == F_ONE) begin
      o_y = '0;
    end else begin
      o_y = F_Q - (i_x - F_ONE);
    end
  end

endmodule

// File: rtl/pergate_sequencer.sv
// rtl/pergate_sequencer.sv - sumcheck round sequencer for a pergate_compute bank (optional PERGATE_SEQ_WATCHDOG_EN)
module pergate_sequencer
  import pergate_seq_pkg::*;
#(
  parameter int                 ngates      = 2,
  parameter int                 nrounds     = 9,
  parameter logic [nrounds-1:0] precomp_dfl = nrounds'(9'o003)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic [F_NBITS-1:0]               i_tau_in,
  input  logic                             i_tau_valid,
  output logic                             o_tau_req,
  output logic [F_NBITS-1:0]               o_tau,
  output logic [F_NBITS-1:0]               o_m_tau_p1,
  input  logic [ngates-1:0]                i_unit_ready,
  output logic                             o_unit_restart,
  output logic                             o_unit_en,
  output logic                             o_unit_precomp,
  output logic [round_width(nrounds)-1:0]  o_round,
  output logic                             o_busy,
  output logic                             o_done
`ifdef PERGATE_SEQ_WATCHDOG_EN
  ,
  output logic                             o_timeout
`endif
);

  localparam int             RW         = round_width(nrounds);
  localparam logic [RW-1:0]  LAST_ROUND = RW'(nrounds - 1);

  seq_state_t                r_state;
  seq_state_t                w_next;
  logic [nrounds-1:0]        r_precomp;
  logic [RW-1:0]             r_round;
  logic [F_NBITS-1:0]        r_tau;
  logic [F_NBITS-1:0]        r_m_tau_p1;
  logic                      r_rdy_armed;
  logic                      w_all_rdy;
  logic                      w_fire_ok;
  logic [F_NBITS-1:0]        w_one_minus;

  assign w_all_rdy = &i_unit_ready;
  assign w_fire_ok = w_all_rdy && r_rdy_armed;

  field_one_minus u_one_minus (
    .i_x (i_tau_in),
    .o_y (w_one_minus)
  );

`ifdef PERGATE_SEQ_WATCHDOG_EN
  logic [15:0] r_wd_cnt;
  logic        w_timeout;

  // Watchdog counts cycles spent in WAIT_RDY; leaving the state clears it, so every entry starts at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wd_cnt <= '0;
    end else if (r_state != S_WAIT_RDY) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt != 16'hFFFF) begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  assign o_timeout = w_timeout;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    w_next         = r_state;
    o_tau_req      = 1'b0;
    o_unit_restart = 1'b0;
    o_unit_en      = 1'b0;
    o_done         = 1'b0;
    o_busy         = (r_state != S_IDLE);
    // Precomp bit is only meaningful while a pass is running.
    o_unit_precomp = (r_state != S_IDLE) && r_precomp[0];
`ifdef PERGATE_SEQ_WATCHDOG_EN
    w_timeout      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = S_RESTART;
        end
      end
      S_RESTART: begin
        o_unit_restart = 1'b1;
        w_next         = S_WAIT_TAU;
      end
      S_WAIT_TAU: begin
        o_tau_req = 1'b1;
        if (i_tau_valid) begin
          w_next = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (w_fire_ok) begin
          w_next = S_FIRE;
        end
`ifdef PERGATE_SEQ_WATCHDOG_EN
        else if (r_wd_cnt == 16'hFFFF) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
`endif
      end
      S_FIRE: begin
        o_unit_en = 1'b1;
        w_next    = (r_round == LAST_ROUND) ? S_DONE : S_WAIT_TAU;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Pass datapath: precomp shifter, round index and the registered challenge pair.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_precomp  <= precomp_dfl;
      r_round    <= '0;
      r_tau      <= '0;
      r_m_tau_p1 <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_round <= '0;
        end
        S_RESTART: begin
          r_precomp <= precomp_dfl;
          r_round   <= '0;
        end
        S_WAIT_TAU: begin
          if (i_tau_valid) begin
            r_tau      <= i_tau_in;
            r_m_tau_p1 <= w_one_minus;
          end
        end
        S_FIRE: begin
          r_precomp <= r_precomp >> 1;
          // The final round index is left in place so it is visible alongside done.
          if (r_round != LAST_ROUND) begin
            r_round <= r_round + RW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Ready must be seen low after each enable before it can fire the next one;
  // restart arms it so the first round only needs the ready level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdy_armed <= 1'b0;
    end else if (r_state == S_RESTART) begin
      r_rdy_armed <= 1'b1;
    end else if (r_state == S_FIRE) begin
      r_rdy_armed <= 1'b0;
    end else if (!w_all_rdy) begin
      r_rdy_armed <= 1'b1;
    end
  end

  assign o_tau      = r_tau;
  assign o_m_tau_p1 = r_m_tau_p1;
  assign o_round    = r_round;

endmodule

// File: tb/tb_pergate_sequencer.sv
// tb/tb_pergate_sequencer.sv - scoreboard bench for pergate_sequencer
module tb_pergate_sequencer;
  import pergate_seq_pkg::*;

  localparam int NG = 2;
  localparam int NR = 9;
  localparam int RW = round_width(NR);

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [F_NBITS-1:0] tau_in;
  logic               tau_valid;
  logic               tau_req;
  logic [F_NBITS-1:0] tau;
  logic [F_NBITS-1:0] m_tau_p1;
  logic [NG-1:0]      unit_ready;
  logic               unit_restart;
  logic               unit_en;
  logic               unit_precomp;
  logic [RW-1:0]      round;
  logic               busy;
  logic               done;
`ifdef PERGATE_SEQ_WATCHDOG_EN
  logic               timeout;
`endif

  logic               auto_mode;
  logic [NG-1:0]      auto_rdy;
  logic [NG-1:0]      man_rdy;
  assign unit_ready = auto_mode ? auto_rdy : man_rdy;

  always #5 clk = ~clk;

  pergate_sequencer #(
    .ngates      (NG),
    .nrounds     (NR),
    .precomp_dfl (9'o003)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_tau_in       (tau_in),
    .i_tau_valid    (tau_valid),
    .o_tau_req      (tau_req),
    .o_tau          (tau),
    .o_m_tau_p1     (m_tau_p1),
    .i_unit_ready   (unit_ready),
    .o_unit_restart (unit_restart),
    .o_unit_en      (unit_en),
    .o_unit_precomp (unit_precomp),
    .o_round        (round),
    .o_busy         (busy),
    .o_done         (done)
`ifdef PERGATE_SEQ_WATCHDOG_EN
    ,
    .o_timeout      (timeout)
`endif
  );

  typedef struct {
    logic               pc;
    logic [F_NBITS-1:0] tv;
    logic [F_NBITS-1:0] mv;
    logic [RW-1:0]      rnd;
  } en_exp_t;

  en_exp_t en_q[$];
  int      done_q[$];
  int      restart_q[$];
  en_exp_t e;

  int n_cmp = 0;
  int n_bad = 0;
  int n_en = 0;
  int n_done = 0;
  int n_restart = 0;
  int cd = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_en(input logic pc, input logic [F_NBITS-1:0] tv,
                         input logic [F_NBITS-1:0] mv, input int rnd);
    en_exp_t x;
    x.pc  = pc;
    x.tv  = tv;
    x.mv  = mv;
    x.rnd = RW'(rnd);
    en_q.push_back(x);
  endtask

  // Monitor: every enable, done and restart pulse is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (unit_en) begin
      n_en++;
      if (en_q.size() == 0) begin
        chk("unexpected_en", 1, 0);
      end else begin
        e = en_q.pop_front();
        chk("en_precomp", unit_precomp, e.pc);
        chk("en_tau", tau, e.tv);
        chk("en_m_tau_p1", m_tau_p1, e.mv);
        chk("en_round", round, e.rnd);
      end
    end
    if (done) begin
      n_done++;
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_round", round, done_q.pop_front());
    end
    if (unit_restart) begin
      n_restart++;
      if (restart_q.size() == 0) chk("unexpected_restart", 1, 0);
      else void'(restart_q.pop_front());
    end
  end

  // Unit bank model: ready drops on enable and returns two cycles later.
  always @(negedge clk) begin
    if (unit_en) begin
      auto_rdy = 2'b00;
      cd = 2;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) auto_rdy = 2'b11;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_latency", unit_restart, 1);
  endtask

  task automatic give_tau(input logic [F_NBITS-1:0] val, input int hold,
                          input logic [F_NBITS-1:0] prev, input logic [F_NBITS-1:0] exp_m);
    int k = 0;
    while (!tau_req && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!tau_req) begin
      chk("tau_req_timeout", 0, 1);
    end else begin
      for (int i = 0; i < hold; i++) begin
        chk("bp_tau_req", tau_req, 1);
        chk("bp_no_en", unit_en, 0);
        chk("bp_tau_hold", tau, prev);
        @(negedge clk);
      end
      tau_in = val;
      tau_valid = 1'b1;
      @(negedge clk);
      tau_valid = 1'b0;
      chk("tau_reg", tau, val);
      chk("m_tau_p1_reg", m_tau_p1, exp_m);
    end
  endtask

  task automatic wait_en(input int target);
    int k = 0;
    while (n_en < target && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (n_en < target) chk("wait_en_timeout", n_en, target);
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (n_done < target && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (n_done < target) chk("wait_done_timeout", n_done, target);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_tau_req"}, tau_req, 0);
    chk({tag, "_tau"}, tau, 0);
    chk({tag, "_m_tau_p1"}, m_tau_p1, 0);
    chk({tag, "_restart"}, unit_restart, 0);
    chk({tag, "_en"}, unit_en, 0);
    chk({tag, "_precomp"}, unit_precomp, 0);
    chk({tag, "_round"}, round, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  logic [F_NBITS-1:0] t2 [NR];
  logic [F_NBITS-1:0] m2 [NR];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tau_in = '0;
    tau_valid = 1'b0;
    auto_mode = 1'b1;
    auto_rdy = 2'b11;
    man_rdy = 2'b00;

    cycles(3);
    chk_idle_outputs("reset");
    rst = 1'b0;
    cycles(1);
    chk_idle_outputs("post_reset");

    // Nominal pass: tau_valid tied high, tau = 5, start re-asserted mid-pass.
    tau_valid = 1'b1;
    tau_in = F_NBITS'(5);
    for (int r = 0; r < NR; r++) push_en(r < 2, F_NBITS'(5), F_Q - F_NBITS'(4), r);
    done_q.push_back(8);
    restart_q.push_back(1);
    pulse_start();
    cycles(3);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    wait_done(1);
    tau_valid = 1'b0;
    cycles(2);
    chk("nom_en_count", n_en, 9);
    chk("nom_restart_count", n_restart, 1);
    chk("nom_busy_cleared", busy, 0);
    chk("nom_m_tau_hold", m_tau_p1, F_Q - F_NBITS'(4));
    chk("nom_en_q_empty", en_q.size(), 0);

    // Field boundaries plus ten cycles of tau backpressure in round 3.
    t2[0] = '0;             m2[0] = F_NBITS'(1);
    t2[1] = F_NBITS'(1);    m2[1] = '0;
    t2[2] = F_Q - F_ONE;    m2[2] = F_NBITS'(2);
    for (int r = 3; r < NR; r++) begin
      t2[r] = F_NBITS'(5);
      m2[r] = F_Q - F_NBITS'(4);
    end
    for (int r = 0; r < NR; r++) push_en(r < 2, t2[r], m2[r], r);
    done_q.push_back(8);
    restart_q.push_back(1);
    pulse_start();
    for (int r = 0; r < NR; r++) give_tau(t2[r], (r == 3) ? 10 : 0, (r > 0) ? t2[r-1] : '0, m2[r]);
    wait_done(2);
    cycles(2);
    chk("fb_en_count", n_en, 18);
    chk("fb_busy_cleared", busy, 0);

    // Ready qualification, then reset in round 4.
    auto_mode = 1'b0;
    man_rdy = 2'b11;
    restart_q.push_back(1);
    push_en(1'b1, F_NBITS'(7), F_Q - F_NBITS'(6), 0);
    pulse_start();
    give_tau(F_NBITS'(7), 0, '0, F_Q - F_NBITS'(6));
    wait_en(19);
    give_tau(F_NBITS'(9), 0, '0, F_Q - F_NBITS'(8));
    cycles(20);
    chk("stale_ready_no_en", n_en, 19);
    man_rdy = 2'b00;
    cycles(1);
    man_rdy = 2'b01;
    cycles(5);
    chk("partial_ready_no_en", n_en, 19);
    push_en(1'b1, F_NBITS'(9), F_Q - F_NBITS'(8), 1);
    man_rdy = 2'b11;
    wait_en(20);
    man_rdy = 2'b00;
    give_tau(F_NBITS'(12), 0, '0, F_Q - F_NBITS'(11));
    push_en(1'b0, F_NBITS'(12), F_Q - F_NBITS'(11), 2);
    man_rdy = 2'b11;
    wait_en(21);
    man_rdy = 2'b00;
    give_tau(F_NBITS'(13), 0, '0, F_Q - F_NBITS'(12));
    push_en(1'b0, F_NBITS'(13), F_Q - F_NBITS'(12), 3);
    man_rdy = 2'b11;
    wait_en(22);
    man_rdy = 2'b00;
    give_tau(F_NBITS'(20), 0, '0, F_Q - F_NBITS'(19));
    cycles(2);
    chk("r4_busy", busy, 1);
    chk("r4_round", round, 4);
    rst = 1'b1;
    cycles(1);
    chk_idle_outputs("midpass_reset");
    rst = 1'b0;
    man_rdy = 2'b11;
    cycles(3);
    man_rdy = 2'b00;
    cycles(3);
    man_rdy = 2'b11;
    cycles(14);
    chk_idle_outputs("after_reset");
    chk("after_reset_en_count", n_en, 22);
    chk("total_restart_count", n_restart, 3);

`ifdef PERGATE_SEQ_WATCHDOG_EN
    begin
      int idx = 0;
      int done_before = n_done;
      man_rdy = 2'b00;
      restart_q.push_back(1);
      pulse_start();
      give_tau(F_NBITS'(3), 0, '0, F_Q - F_NBITS'(2));
      while (!timeout && idx < 70000) begin
        @(negedge clk);
        idx++;
      end
      chk("wd_latency", idx, 65535);
      cycles(1);
      chk("wd_busy_cleared", busy, 0);
      chk("wd_no_done", n_done, done_before);
    end
`endif

    chk("final_en_q_empty", en_q.size(), 0);
    chk("final_done_q_empty", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pergate_sequencer.md
Name: pergate_sequencer

Overview:
Control FSM that drives a bank of per-gate compute units through one sumcheck layer pass of `nrounds` rounds.
- Start of pass: issues restart to every unit.
- Each round: requests a fresh tau from the verifier-side requester, then registers tau and m_tau_p1 = (1 - tau) mod q.
- Pulses unit enable once all units report ready, and shifts the precomp bit vector.
- Sits between the layer controller (start/done) and the pergate_compute bank.

Parameters:
- ngates, 2, number of compute units sequenced (width of unit_ready).
- nrounds, 9, rounds per pass (equals unit nidbits).
- precomp_dfl, 9'o003, precomp vector loaded at restart; LSB consumed first. Width is nrounds.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a pass; ignored unless idle.
- tau_in  in  F_NBITS  round challenge, reduced mod F_Q.
- tau_valid  in  1  tau_in valid; consumed when tau_req & tau_valid.
- tau_req  out  1  sequencer is waiting for a challenge.
- tau  out  F_NBITS  registered challenge to units.
- m_tau_p1  out  F_NBITS  registered (1 - tau) mod F_Q.
- unit_ready  in  ngates  per-unit ready levels.
- unit_restart  out  1  one-cycle restart to all units.
- unit_en  out  1  one-cycle enable to all units.
- unit_precomp  out  1  current precomp bit (LSB of shift register).
- round  out  $clog2(nrounds+1)  index of the current round.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at pass completion.

Behaviour:
- Reset values:
  - state IDLE; all outputs 0; precomp shift register = precomp_dfl.
  - Reset is honoured from any state, mid-pass included; no further unit_en is issued after it.
- States: IDLE, RESTART, WAIT_TAU, WAIT_RDY, FIRE, DONE.
- IDLE: on start, go to RESTART and set busy. round=0.
- RESTART:
  - unit_restart=1 for exactly this cycle.
  - Load precomp register with precomp_dfl; go to WAIT_TAU.
- WAIT_TAU:
  - tau_req=1.
  - On tau_valid, register tau=tau_in and m_tau_p1 in the same edge; go to WAIT_RDY.
  - m_tau_p1 rule: tau==0 gives 1; tau==1 gives 0; otherwise F_Q+1-tau.
- WAIT_RDY:
  - Requires &unit_ready to be high, and to have been low at least once since the last unit_en. This is edge qualification, so stale ready from the previous round is not reused.
  - Exception: the first round after RESTART needs only the level.
  - When satisfied, go to FIRE.
- FIRE:
  - unit_en=1 for exactly this cycle; unit_precomp is stable during this cycle.
  - At the edge, shift the precomp register right (zero fill) and increment round.
  - If round==nrounds-1, go to DONE; otherwise go to WAIT_TAU.
- DONE: done=1 for one cycle; busy drops the next cycle; return to IDLE.
- start while busy: ignored; no queuing.
- tau and m_tau_p1 hold between updates; units see them stable from WAIT_RDY through FIRE.
- Latency from accepted start:
  - unit_restart at +1.
  - First unit_en at the earliest 3 cycles after tau_valid is seen with all units ready.
- nrounds=1: one FIRE, then DONE.

Optional Feature:
- Macro PERGATE_SEQ_WATCHDOG_EN.
- Defined:
  - A 16-bit counter runs in WAIT_RDY.
  - If it reaches 16'hFFFF, the sequencer asserts an extra output port `timeout` for one cycle, drops to IDLE without done, and clears busy.
  - The counter clears on each entry to WAIT_RDY.
- Undefined: no port, no counter; WAIT_RDY waits indefinitely.

Decomposition:
- Shared package pergate_seq_pkg holds:
  - the state enum (6 states, 3-bit);
  - the round-width helper function;
  - the F_Q-based constant for 1 in field width.
- One sub-module: field_one_minus, the combinational (1 - x) mod F_Q used for m_tau_p1. It is reusable by other layer controllers.

Test Plan:
- Nominal pass:
  - Stimulus: ngates=2, nrounds=9; start pulse; tau_valid tied high, tau_in=5; units ready 2 cycles after each enable.
  - Required: exactly 1 unit_restart and 9 unit_en pulses. unit_precomp sequence on enables is 1,1,0,0,0,0,0,0,0. done once, round ends at 8, m_tau_p1=F_Q-4.
- Field boundary:
  - Stimulus: tau_in sequence 0, 1, F_Q-1.
  - Required: m_tau_p1 = 1, 0, 2 respectively.
- Ready qualification:
  - Stimulus: hold unit_ready=2'b11 permanently after the first enable.
  - Required: second unit_en never fires until ready drops and reasserts. Staggered ready (2'b01, then 2'b11) fires only on all-high.
- Backpressure on tau:
  - Stimulus: tau_valid low for 10 cycles in round 3.
  - Required: tau_req held, no unit_en, tau unchanged until acceptance.
- Reset and restart hygiene:
  - Stimulus: rst in round 4; start asserted while busy.
  - Required: after rst, all outputs 0 with no enable. Start while busy causes no second restart.
- Watchdog (macro defined):
  - Stimulus: unit_ready stuck low.
  - Required: timeout pulses 65535 cycles after entering WAIT_RDY; busy clears; no done.
